// File: rtl/dmni_rx_frontend_if.sv
// Channel ingress and merged-stream signals of the DMNI receive front-end.
// The front-end connects through the slave modport; its environment uses master.
interface dmni_rx_frontend_if #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]           rx_i;
  logic [N_CH-1:0]           eop_i;
  logic [N_CH-1:0]           credit_o;
  logic [N_CH*FLIT_SIZE-1:0] data_i;
  logic                      tx_o;
  logic                      eop_o;
  logic                      ack_i;
  logic [FLIT_SIZE-1:0]      data_o;
  logic [CH_W-1:0]           ch_o;
  logic [31:0]               ts_o;

  modport master (
    output rx_i, eop_i, data_i, ack_i,
    input  credit_o, tx_o, eop_o, data_o, ch_o, ts_o
  );

  modport slave (
    input  rx_i, eop_i, data_i, ack_i,
    output credit_o, tx_o, eop_o, data_o, ch_o, ts_o
  );
endinterface

// File: rtl/dmni_rx_frontend.sv
// N-channel DMNI receive front-end: per-channel credit ring buffers merged by a
// packet-atomic round-robin arbiter. Define DMNI_RX_TIMESTAMP_EN to store write timestamps.
module dmni_rx_frontend #(
  parameter int N_CH        = 2,
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 16,
  parameter int CUT_THROUGH = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [31:0]                             tick_counter_i,
  input  logic [N_CH-1:0]                         flush_i,
  dmni_rx_frontend_if.slave                       bus,
  output logic [N_CH*$clog2(BUFFER_SIZE+1)-1:0]   pkt_pending_o
);
  localparam int AW   = $clog2(BUFFER_SIZE);
  localparam int PW   = AW + 1;
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNTW = $clog2(BUFFER_SIZE + 1);
`ifdef DMNI_RX_TIMESTAMP_EN
  localparam int TSW  = 32;
`else
  localparam int TSW  = 0;
`endif
  localparam int EW   = TSW + 1 + FLIT_SIZE;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  logic [EW-1:0]   r_mem  [N_CH][BUFFER_SIZE];
  logic [PW-1:0]   r_wptr [N_CH];
  logic [PW-1:0]   r_rptr [N_CH];
  logic [CNTW-1:0] r_pend [N_CH];
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_lock_ch, w_lock_nxt;
  logic [CW-1:0]   r_prio, w_prio_nxt;

  logic [N_CH-1:0] w_empty, w_full, w_elig;
  logic [N_CH-1:0] w_wr, w_rd, w_pend_inc, w_pend_dec;
  logic [EW-1:0]   w_head  [N_CH];
  logic [EW-1:0]   w_entry [N_CH];
  logic [EW-1:0]   w_gh;
  logic [CW-1:0]   w_pick, w_grant;
  logic            w_found, w_tx, w_pop, w_head_eop;

  // Per-channel occupancy from wrap-bit pointers
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_empty[c] = (r_wptr[c] == r_rptr[c]);
      w_full[c]  = (r_wptr[c][AW] != r_rptr[c][AW]) &&
                   (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]);
      w_head[c]  = r_mem[c][r_rptr[c][AW-1:0]];
      w_elig[c]  = (CUT_THROUGH != 0) ? !w_empty[c] : (r_pend[c] != '0);
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
`ifdef DMNI_RX_TIMESTAMP_EN
      w_entry[c] = {tick_counter_i, bus.eop_i[c], bus.data_i[c*FLIT_SIZE +: FLIT_SIZE]};
`else
      w_entry[c] = {bus.eop_i[c], bus.data_i[c*FLIT_SIZE +: FLIT_SIZE]};
`endif
      w_wr[c]       = bus.rx_i[c] && !w_full[c] && !flush_i[c];
      w_pend_inc[c] = w_wr[c] && bus.eop_i[c];
    end
  end

`ifndef DMNI_RX_TIMESTAMP_EN
  logic w_unused_tick;
  assign w_unused_tick = ^tick_counter_i;
`endif

  // Arbiter: round-robin search from the priority pointer, held while LOCKED
  always_comb begin
    logic [CW-1:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = CW'((i + 32'(r_prio)) % 32'(N_CH));
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end

    if (r_state == ST_LOCKED) begin
      w_grant = r_lock_ch;
      w_tx    = !w_empty[r_lock_ch] && !flush_i[r_lock_ch];
    end else begin
      w_grant = w_pick;
      w_tx    = w_found && !flush_i[w_pick];
    end
    w_pop      = w_tx && bus.ack_i;
    w_gh       = w_head[w_grant];
    w_head_eop = w_gh[FLIT_SIZE];

    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_ch;
    w_prio_nxt  = r_prio;
    case (r_state)
      ST_IDLE: begin
        if (w_pop && !w_head_eop) begin
          w_state_nxt = ST_LOCKED;
          w_lock_nxt  = w_grant;
        end
      end
      ST_LOCKED: begin
        if (flush_i[r_lock_ch] || (w_pop && w_head_eop))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop && w_head_eop)
      w_prio_nxt = (w_grant == CW'(N_CH - 1)) ? '0 : w_grant + CW'(1);
  end

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_rd[c]       = w_pop && (w_grant == CW'(c));
      w_pend_dec[c] = w_rd[c] && w_head[c][FLIT_SIZE];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_prio    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_nxt;
      r_prio    <= w_prio_nxt;
    end
  end

  // Flush wins over any same-cycle write or pop on that channel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_pend[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (flush_i[c]) begin
          r_wptr[c] <= '0;
          r_rptr[c] <= '0;
          r_pend[c] <= '0;
        end else begin
          if (w_wr[c]) r_wptr[c] <= r_wptr[c] + PW'(1);
          if (w_rd[c]) r_rptr[c] <= r_rptr[c] + PW'(1);
          if (w_pend_inc[c] && !w_pend_dec[c])
            r_pend[c] <= r_pend[c] + CNTW'(1);
          else if (!w_pend_inc[c] && w_pend_dec[c])
            r_pend[c] <= r_pend[c] - CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (w_wr[c]) r_mem[c][r_wptr[c][AW-1:0]] <= w_entry[c];
    end
  end

  // Head fields are gated by tx so that unwritten storage never reaches the outputs
  assign bus.credit_o = ~w_full;
  assign bus.tx_o     = w_tx;
  assign bus.eop_o    = w_tx && w_head_eop;
  assign bus.data_o   = w_tx ? w_gh[FLIT_SIZE-1:0] : '0;
  assign bus.ch_o     = w_grant;
`ifdef DMNI_RX_TIMESTAMP_EN
  assign bus.ts_o     = w_tx ? w_gh[EW-1 -: 32] : '0;
`else
  assign bus.ts_o     = '0;
`endif

  always_comb begin
    pkt_pending_o = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      pkt_pending_o[c*CNTW +: CNTW] = r_pend[c];
  end
endmodule

// File: tb/tb_dmni_rx_frontend.sv
// Bench for dmni_rx_frontend: cut-through and store-and-forward instances, table
// vectors for credit/flush/lock corners, per-channel scoreboards for merged streams.
module tb_dmni_rx_frontend;
  localparam int N     = 2;
  localparam int FW    = 32;
  localparam int BS    = 4;
  localparam int PENDW = N * $clog2(BS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      tick;
  logic [N-1:0]     flush_a, flush_b;
  logic [PENDW-1:0] pend_a, pend_b;

  always #5 clk = ~clk;

  dmni_rx_frontend_if #(.N_CH(N), .FLIT_SIZE(FW)) if_a ();
  dmni_rx_frontend_if #(.N_CH(N), .FLIT_SIZE(FW)) if_b ();

  dmni_rx_frontend #(.N_CH(N), .FLIT_SIZE(FW), .BUFFER_SIZE(BS), .CUT_THROUGH(1)) u_ct (
    .clk_i(clk), .rst_ni(rst_n), .tick_counter_i(tick), .flush_i(flush_a),
    .bus(if_a.slave), .pkt_pending_o(pend_a));

  dmni_rx_frontend #(.N_CH(N), .FLIT_SIZE(FW), .BUFFER_SIZE(BS), .CUT_THROUGH(0)) u_sf (
    .clk_i(clk), .rst_ni(rst_n), .tick_counter_i(tick), .flush_i(flush_b),
    .bus(if_b.slave), .pkt_pending_o(pend_b));

  typedef struct packed {
    logic [31:0] data;
    logic        eop;
    logic [31:0] ts;
  } flit_t;

  typedef struct {
    logic [1:0]  rx;
    logic [1:0]  eop;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ack;
    logic [1:0]  flush;
    logic [1:0]  credit;
    logic        tx;
    logic        ch;
    logic [31:0] dout;
    logic [5:0]  pend;
  } vec_t;

  flit_t qa0[$], qa1[$], qb0[$], qb1[$];
  logic  orda[$], ordb[$];
  int    checks = 0;
  int    errors = 0;
  bit    sb_en  = 1'b0;
  vec_t  vt[19];

  function automatic vec_t mk(input logic [1:0] rx, input logic [1:0] eop, input logic [31:0] d0,
                              input logic [31:0] d1, input logic ack, input logic [1:0] flush,
                              input logic [1:0] credit, input logic tx, input logic ch,
                              input logic [31:0] dout, input logic [5:0] pend);
    vec_t v;
    v.rx = rx; v.eop = eop; v.d0 = d0; v.d1 = d1; v.ack = ack; v.flush = flush;
    v.credit = credit; v.tx = tx; v.ch = ch; v.dout = dout; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic clear_inputs();
    if_a.rx_i = '0; if_a.eop_i = '0; if_a.data_i = '0;
    if_b.rx_i = '0; if_b.eop_i = '0; if_b.data_i = '0;
    flush_a = '0; flush_b = '0;
  endtask

  task automatic wr(input bit is_b, input int c, input logic [31:0] d, input logic e);
    flit_t f;
    f.data = d;
    f.eop  = e;
`ifdef DMNI_RX_TIMESTAMP_EN
    f.ts = tick;
`else
    f.ts = '0;
`endif
    if (!is_b) begin
      if_a.rx_i[c] = 1'b1; if_a.eop_i[c] = e; if_a.data_i[c*FW +: FW] = d;
      if (c == 0) qa0.push_back(f); else qa1.push_back(f);
    end else begin
      if_b.rx_i[c] = 1'b1; if_b.eop_i[c] = e; if_b.data_i[c*FW +: FW] = d;
      if (c == 0) qb0.push_back(f); else qb1.push_back(f);
    end
  endtask

  task automatic sb_pop(input bit is_b, input logic ch, input logic [31:0] d,
                        input logic e, input logic [31:0] ts);
    flit_t exp;
    logic  ech;
    bit    ok;
    checks++;
    ech = 1'b0;
    exp = '0;
    ok  = is_b ? (ordb.size() > 0) : (orda.size() > 0);
    if (ok) ech = is_b ? ordb.pop_front() : orda.pop_front();
    if (ok) begin
      if (!is_b && !ech)     begin ok = qa0.size() > 0; if (ok) exp = qa0.pop_front(); end
      else if (!is_b)        begin ok = qa1.size() > 0; if (ok) exp = qa1.pop_front(); end
      else if (!ech)         begin ok = qb0.size() > 0; if (ok) exp = qb0.pop_front(); end
      else                   begin ok = qb1.size() > 0; if (ok) exp = qb1.pop_front(); end
    end
    if (!ok) begin
      errors++;
      $display("FAIL sb_unexpected dut=%0d actual ch=%0d data=%h required no output", is_b, ch, d);
    end else if (ch !== ech || d !== exp.data || e !== exp.eop || ts !== exp.ts) begin
      errors++;
      $display("FAIL sb_flit dut=%0d actual ch=%0d data=%h eop=%0d ts=%h required ch=%0d data=%h eop=%0d ts=%h",
               is_b, ch, d, e, ts, ech, exp.data, exp.eop, exp.ts);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (sb_en) begin
      if (if_a.tx_o && if_a.ack_i) sb_pop(1'b0, if_a.ch_o, if_a.data_o, if_a.eop_o, if_a.ts_o);
      if (if_b.tx_o && if_b.ack_i) sb_pop(1'b1, if_b.ch_o, if_b.data_o, if_b.eop_o, if_b.ts_o);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    tick = tick + 32'd1;
    clear_inputs();
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((orda.size() != 0 || ordb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (orda.size() != 0 || ordb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual pending=%0d required pending=0", nm, orda.size() + ordb.size());
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    if_a.ack_i = 1'b0;
    if_b.ack_i = 1'b0;
    tick = 32'h100;
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete(); orda.delete(); ordb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rx, eop, d0, d1, ack, flush | credit, tx, ch, dout, pend
    vt[0]  = mk(2'b01, 2'b01, 32'h10, 32'h0,  1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,  6'h00);
    vt[1]  = mk(2'b01, 2'b01, 32'h11, 32'h0,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 32'h10, 6'h01);
    vt[2]  = mk(2'b01, 2'b01, 32'h12, 32'h0,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 32'h10, 6'h02);
    vt[3]  = mk(2'b01, 2'b01, 32'h13, 32'h0,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 32'h10, 6'h03);
    vt[4]  = mk(2'b01, 2'b01, 32'h14, 32'h0,  1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 32'h10, 6'h04);
    vt[5]  = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 32'h10, 6'h04);
    vt[6]  = mk(2'b01, 2'b01, 32'h15, 32'h0,  1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 32'h11, 6'h03);
    vt[7]  = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 32'h12, 6'h03);
    vt[8]  = mk(2'b01, 2'b01, 32'h16, 32'h0,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 32'h12, 6'h03);
    vt[9]  = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 32'h12, 6'h04);
    vt[10] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 32'h0,  6'h04);
    vt[11] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,  6'h00);
    vt[12] = mk(2'b01, 2'b00, 32'h20, 32'h0,  1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,  6'h00);
    vt[13] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 32'h20, 6'h00);
    vt[14] = mk(2'b10, 2'b10, 32'h0,  32'h30, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,  6'h00);
    vt[15] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,  6'h08);
    vt[16] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 32'h0,  6'h08);
    vt[17] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 2'b11, 1'b1, 1'b1, 32'h30, 6'h08);
    vt[18] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,  6'h00);

    rst_n = 1'b0;
    do_reset();

    sample();
    chk("rst_credit_a", 64'(if_a.credit_o), 64'h3);
    chk("rst_tx_a",     64'(if_a.tx_o),     64'h0);
    chk("rst_eop_a",    64'(if_a.eop_o),    64'h0);
    chk("rst_ch_a",     64'(if_a.ch_o),     64'h0);
    chk("rst_data_a",   64'(if_a.data_o),   64'h0);
    chk("rst_ts_a",     64'(if_a.ts_o),     64'h0);
    chk("rst_pend_a",   64'(pend_a),        64'h0);
    chk("rst_credit_b", 64'(if_b.credit_o), 64'h3);
    chk("rst_pend_b",   64'(pend_b),        64'h0);
    adv();

    for (int i = 0; i < 19; i++) begin
      if_a.rx_i   = vt[i].rx;
      if_a.eop_i  = vt[i].eop;
      if_a.data_i = {vt[i].d1, vt[i].d0};
      if_a.ack_i  = vt[i].ack;
      flush_a     = vt[i].flush;
      sample();
      chk($sformatf("v%0d_credit", i), 64'(if_a.credit_o), 64'(vt[i].credit));
      chk($sformatf("v%0d_tx", i),     64'(if_a.tx_o),     64'(vt[i].tx));
      chk($sformatf("v%0d_ch", i),     64'(if_a.ch_o),     64'(vt[i].ch));
      chk($sformatf("v%0d_data", i),   64'(if_a.data_o),   64'(vt[i].dout));
      chk($sformatf("v%0d_pend", i),   64'(pend_a),        64'(vt[i].pend));
      adv();
    end

    // Two packets in parallel: ch0 3 flits, then ch1 2 flits, no interleaving
    do_reset();
    sb_en = 1'b1;
    if_a.ack_i = 1'b1;
    orda = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr(1'b0, 0, 32'hA0, 1'b0); wr(1'b0, 1, 32'hB0, 1'b0); step();
    wr(1'b0, 0, 32'hA1, 1'b0); wr(1'b0, 1, 32'hB1, 1'b1); step();
    wr(1'b0, 0, 32'hA2, 1'b1); step();
    drain("pkt_order", 12);

    // Single-flit packets on both channels alternate starting at ch0
    do_reset();
    if_a.ack_i = 1'b1;
    orda = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      wr(1'b0, 0, 32'hC0 + 32'(k), 1'b1);
      wr(1'b0, 1, 32'hD0 + 32'(k), 1'b1);
      step();
    end
    drain("fairness", 12);

    // Store-and-forward: incomplete ch1 packet waits behind complete ch0 packet
    do_reset();
    if_b.ack_i = 1'b1;
    ordb = '{1'b0, 1'b1, 1'b1, 1'b1};
    wr(1'b1, 0, 32'hE0, 1'b1); wr(1'b1, 1, 32'hF0, 1'b0); step();
    wr(1'b1, 1, 32'hF1, 1'b0);
    sample(); chk("sf_pend_ch0", 64'(pend_b), 64'h01); adv();
    sample(); chk("sf_ch1_held", 64'(if_b.tx_o), 64'h0); adv();
    wr(1'b1, 1, 32'hF2, 1'b1);
    sample(); chk("sf_ch1_held2", 64'(if_b.tx_o), 64'h0); adv();
    sample();
    chk("sf_pend_ch1", 64'(pend_b), 64'h08);
    chk("sf_ch1_grant", 64'({if_b.tx_o, if_b.ch_o}), 64'h3);
    adv();
    drain("sf_order", 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
